data_mem_responder: RTL and testbench

- Memory-side responder for the core's data port: it accepts load/store requests and answers them, the other end of the core's mem_addr/mem_data/mem_we interface.
- Word-addressed synchronous RAM, a programmable wait-state counter and a small MMIO window (console byte, halt flag, cycle counter).
- Handles one outstanding request at a time via a valid/ready request channel and a single-cycle response pulse.
- Replaces the zero-wait-state path when the core runs against slower memory or a simulation harness.

---
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port: word RAM, wait states, MMIO window.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [7:0]  console_data,
  output logic        console_valid,
  output logic        halt
);

  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic [31:0]        resp_rdata_q;
  logic [7:0]         console_data_q;
  logic               console_valid_q;
  logic               halt_q;
  logic [31:0]        cycle_q;
  logic [31:0]        ld_data_q, ld_data_d;
  logic               con_pend_q, con_pend_d;

  logic [31:0]        mem_q [DEPTH];

  logic               accept_c;
  logic               is_mmio_c;
  logic [31:0]        mmio_off_c;
  logic [ADDR_W-1:0]  ram_idx_c;
  logic [31:0]        load_val_c;
  logic               con_wr_c;
  logic               halt_wr_c;

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign console_data  = console_data_q;
  assign console_valid = console_valid_q;
  assign halt          = halt_q;

  // Request decode: acceptance, region select and load-value mux.
  always_comb begin
    accept_c   = req_valid & req_ready_q;
    is_mmio_c  = (req_addr >= MMIO_BASE);
    mmio_off_c = req_addr - MMIO_BASE;
    ram_idx_c  = req_addr[ADDR_W-1:0];
    con_wr_c   = accept_c & req_we & is_mmio_c & (mmio_off_c == 32'd0);
    halt_wr_c  = accept_c & req_we & is_mmio_c & (mmio_off_c == 32'd1) & (|req_wdata);
    load_val_c = 32'd0;
    if (!req_we) begin
      if (!is_mmio_c) begin
        load_val_c = mem_q[ram_idx_c];
      end else begin
        case (mmio_off_c)
          32'd1:   load_val_c = {31'd0, halt_q};
          32'd2:   load_val_c = cycle_q;
          default: load_val_c = 32'd0;
        endcase
      end
    end
  end

  // Next-state logic for the IDLE/WAIT/RESP handshake and captured response data.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    ld_data_d  = ld_data_q;
    con_pend_d = con_pend_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d    = (WAIT_CYCLES > 0) ? WAIT : RESP;
          wait_d     = WAIT_LOAD;
          ld_data_d  = load_val_c;
          con_pend_d = con_wr_c;
        end
      end
      WAIT: begin
        if (wait_q == CNT_W'(0)) begin
          state_d = RESP;
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, response and MMIO registers; reset wins over any acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      wait_q          <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      console_data_q  <= '0;
      console_valid_q <= 1'b0;
      halt_q          <= 1'b0;
      cycle_q         <= '0;
      ld_data_q       <= '0;
      con_pend_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_q          <= wait_d;
      req_ready_q     <= (state_d == IDLE);
      resp_valid_q    <= (state_d == RESP);
      console_valid_q <= (state_d == RESP) & con_pend_d;
      cycle_q         <= cycle_q + 32'd1;
      ld_data_q       <= ld_data_d;
      con_pend_q      <= con_pend_d;
      if (state_d == RESP) begin
        resp_rdata_q <= ld_data_d;
      end
      if (con_wr_c) begin
        console_data_q <= req_wdata[7:0];
      end
      if (halt_wr_c) begin
        halt_q <= 1'b1;
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && accept_c && req_we && !is_mmio_c) begin
      mem_q[ram_idx_c] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder with WAIT_CYCLES = 1, 0 and 4 instances.
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam int          DEPTH = 1024;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        cons;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vld = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;

  logic        rdy [3];
  logic        rv  [3];
  logic        cv  [3];
  logic        hlt [3];
  logic [31:0] rd  [3];
  logic [7:0]  cd  [3];

  exp_t        sbq [$];
  int          edge_n = 0;
  logic [31:0] cyc_m = '0;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_addr(addr), .req_wdata(wdata), .req_we(we),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .console_data(cd[1]),
    .console_valid(cv[1]), .halt(hlt[1]));

  data_mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_addr(addr), .req_wdata(wdata), .req_we(we),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .console_data(cd[0]),
    .console_valid(cv[0]), .halt(hlt[0]));

  data_mem_responder #(.WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_addr(addr), .req_wdata(wdata), .req_we(we),
    .resp_valid(rv[2]), .resp_rdata(rd[2]), .console_data(cd[2]),
    .console_valid(cv[2]), .halt(hlt[2]));

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Edge count for latency and the expected free-running cycle counter.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (rst) cyc_m <= '0;
    else     cyc_m <= cyc_m + 32'd1;
  end

  // Response monitor: pop the oldest expectation on every resp_valid.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rv[i]) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", 32'(rv[i]), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("resp_inst", 32'(i), 32'(e.inst));
          check("resp_rdata", rd[i], e.rdata);
          check("latency", 32'(edge_n - e.acc), 32'(wait_of(i) + 1));
          check("console_valid", 32'(cv[i]), 32'(e.cons));
          check("ready_in_resp", 32'(rdy[i]), 32'd0);
        end
      end
    end
  end

  // Issue one request; expectation recorded in the acceptance cycle.
  task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [31:0] exp_rd, input logic exp_cv,
                        input bit track, input bit exp_cyc);
    int n;
    exp_t e;
    @(negedge clk);
    addr = a; wdata = d; we = w; vld[i] = 1'b1;
    n = 0;
    while (!rdy[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) begin
      check("ready_timeout", 32'(rdy[i]), 32'd1);
    end else if (track) begin
      e.inst  = i;
      e.rdata = exp_cyc ? cyc_m : exp_rd;
      e.cons  = exp_cv;
      e.acc   = edge_n;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 vld[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", 32'(rdy[i]), 32'd1);
      check("rst_resp_valid", 32'(rv[i]), 32'd0);
      check("rst_rdata", rd[i], 32'd0);
      check("rst_console", 32'(cd[i]), 32'd0);
      check("rst_console_valid", 32'(cv[i]), 32'd0);
      check("rst_halt", 32'(hlt[i]), 32'd0);
    end

    // cycle counter read right after reset release
    do_req(1, BASE + 32'd2, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    drain();

    // store/load round trip, hold of rdata, aliasing
    do_req(1, 32'd5, 32'hDEAD_BEEF, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    do_req(1, 32'd5, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    check("rdata_hold", rd[1], 32'hDEAD_BEEF);
    do_req(1, 32'd3, 32'h11, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    do_req(1, 32'(DEPTH + 3), 32'd0, 1'b0, 32'h11, 1'b0, 1'b1, 1'b0);
    drain();

    // MMIO window
    do_req(1, BASE, 32'h141, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0);
    drain();
    check("console_data", 32'(cd[1]), 32'h41);
    do_req(1, BASE + 32'd1, 32'd7, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    drain();
    check("halt_set", 32'(hlt[1]), 32'd1);
    do_req(1, BASE + 32'd1, 32'd0, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    drain();
    check("halt_sticky", 32'(hlt[1]), 32'd1);
    do_req(1, BASE + 32'd1, 32'd0, 1'b0, 32'd1, 1'b0, 1'b1, 1'b0);
    do_req(1, BASE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    do_req(1, BASE + 32'd5, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    do_req(1, BASE + 32'd5, 32'h55, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    drain();

    // zero wait states, back-to-back loads with req_valid held
    do_req(0, 32'd7, 32'h0000_A5A5, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    drain();
    @(negedge clk);
    addr = 32'd7; we = 1'b0; vld[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("b2b_ready", 32'(rdy[0]), 32'((k % 2) == 0));
      if (rdy[0]) begin
        exp_t e;
        e.inst = 0; e.rdata = 32'h0000_A5A5; e.cons = 1'b0; e.acc = edge_n;
        sbq.push_back(e);
      end
      @(negedge clk);
    end
    vld[0] = 1'b0;
    drain();

    // reset during WAIT: store committed, no response
    do_req(2, 32'd9, 32'hCAFE_0009, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(rdy[2]), 32'd1);
    check("halt_cleared", 32'(hlt[1]), 32'd0);
    check("console_cleared", 32'(cd[1]), 32'd0);
    repeat (8) @(negedge clk);
    do_req(2, 32'd9, 32'd0, 1'b0, 32'hCAFE_0009, 1'b0, 1'b1, 1'b0);
    drain();

    // cycle counter wrap
    @(negedge clk);
    force u_w1.cycle_q = 32'hFFFF_FFFF;
    #1 release u_w1.cycle_q;
    do_req(1, BASE + 32'd2, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    drain();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
